seg7_scan_mux: RTL

- Downstream display stage for the counter/BCD chain. It takes DIGITS packed BCD digits plus per-digit decimal points.
- It time-multiplexes them onto the shared 7-segment bus and the 3-bit digit select, with inter-digit ghost blanking and optional leading-zero suppression.
- It replaces the fixed single-digit select so multi-digit counter outputs can be shown together.

---
 rtl/seg7_scan_mux.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver: scans DIGITS snapshotted BCD digits onto a
// shared segment bus, blanking the start of every slot and optionally leading zeros.
module seg7_scan_mux #(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 2048,
  parameter int BLANK_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic [2:0]            seg7_sel,
  output logic [6:0]            seg7_out,
  output logic                  dpt_out,
  output logic                  frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [2:0]    IDX_LAST  = 3'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;
  localparam state_t SLOT_START = (BLANK_CYC == 0) ? SHOW : GAP;

  state_t                state, state_nx;
  logic [PW-1:0]         pcnt, pcnt_nx;
  logic [2:0]            idx, idx_nx;
  logic [4*DIGITS-1:0]   snap_bcd, bcd_nx;
  logic [DIGITS-1:0]     snap_dp, dp_nx;
  logic                  snap_lz, lz_nx;
  logic                  done_nx;
  logic                  capture;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pcnt       <= '0;
      idx        <= '0;
      snap_bcd   <= '0;
      snap_dp    <= '0;
      snap_lz    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      pcnt       <= pcnt_nx;
      idx        <= idx_nx;
      snap_bcd   <= bcd_nx;
      snap_dp    <= dp_nx;
      snap_lz    <= lz_nx;
      frame_done <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pcnt_nx  = pcnt;
    idx_nx   = idx;
    done_nx  = 1'b0;
    capture  = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      pcnt_nx  = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = SLOT_START;
          pcnt_nx  = '0;
          idx_nx   = '0;
          capture  = 1'b1;
        end
        GAP: begin
          pcnt_nx = pcnt + PW'(1);
          if (pcnt == GAP_LAST) state_nx = SHOW;
        end
        SHOW: begin
          if (pcnt == PCNT_LAST) begin
            pcnt_nx  = '0;
            state_nx = SLOT_START;
            // Frame boundary: wrap and resample so a frame never mixes old and new digits.
            if (idx == IDX_LAST) begin
              idx_nx  = '0;
              done_nx = 1'b1;
              capture = 1'b1;
            end else begin
              idx_nx = idx + 3'd1;
            end
          end else begin
            pcnt_nx = pcnt + PW'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    bcd_nx = capture ? bcd_in   : snap_bcd;
    dp_nx  = capture ? dp_in    : snap_dp;
    lz_nx  = capture ? lz_blank : snap_lz;
  end

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000000;
    endcase
  endfunction

  logic [3:0] cur_digit;
  logic       cur_dp;
  logic       lz_hit;
  logic       zero_run;

  // zero_run tracks "this digit and every higher digit are zero" walking down from the MSD.
  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    lz_hit    = 1'b0;
    zero_run  = snap_lz;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (snap_bcd[4*i +: 4] == 4'd0);
      if (idx == 3'(i)) begin
        cur_digit = snap_bcd[4*i +: 4];
        cur_dp    = snap_dp[i];
        lz_hit    = zero_run && (i != 0);
      end
    end
  end

  assign seg7_sel = IDX_LAST - idx;
  assign seg7_out = (state == SHOW && !lz_hit) ? decode(cur_digit) : 7'b0000000;
  assign dpt_out  = (state == SHOW) && cur_dp;

endmodule
